// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, the fetch buffer entry type and the JAL target helper.
package fetch_pkg;
  localparam logic [6:0]  OPC_JAL      = 7'b1101111;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} lives in instr[31:12]
  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] instr);
    return pc + {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction-memory read port plus the fetch-to-decode valid/ready handshake.
interface fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  modport master (
    output imem_req_o, imem_addr_o, instr_o, pc_o, valid_o,
    input  imem_rdata_i, ready_i
  );
  modport slave (
    input  imem_req_o, imem_addr_o, instr_o, pc_o, valid_o,
    output imem_rdata_i, ready_i
  );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of {pc, instr} entries with synchronous flush; flush beats push.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;

  // pointers wrap naturally at DEPTH (power of two); storage cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= entry_i;
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, credit-based imem issue, buffered delivery to decode; FETCH_JAL_PREDECODE_EN enables JAL redirect at response time.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        nrst,
  fetch_if.master     bus,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        misalign_o
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d, req_pc_q, jal_pc;
  logic          inflight_q, drop_q, misalign_q, misalign_d;
  logic          pop, push, issue, jal;
  logic [CW-1:0] count;
  logic [CW:0]   credit;
  fetch_entry_t  head;

  assign bus.valid_o = (count != '0) && !redirect_i;
  assign pop         = bus.valid_o && bus.ready_i;
  assign push        = inflight_q && !drop_q;
  assign credit      = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight_q);

`ifdef FETCH_JAL_PREDECODE_EN
  assign jal    = push && !redirect_i && (bus.imem_rdata_i[6:0] == OPC_JAL);
  assign jal_pc = jal_target(req_pc_q, bus.imem_rdata_i);
`else
  assign jal    = 1'b0;
  assign jal_pc = '0;
`endif

  // no request while held in reset, during a redirect, or while redirecting on a JAL
  assign issue = nrst && !redirect_i && !jal && (credit < (CW+1)'(BUF_DEPTH));

  // next PC: external redirect beats predecoded JAL beats sequential advance
  always_comb begin
    pc_d       = redirect_i ? (redirect_pc_i & ~32'h3) : jal ? (jal_pc & ~32'h3) : issue ? pc_q + 32'd4 : pc_q;
    misalign_d = redirect_i ? |redirect_pc_i[1:0] : jal && |jal_pc[1:0];
  end

  // PC, outstanding-request tracking and the one-cycle drop/misalign flags
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if (issue) req_pc_q <= pc_q;
      inflight_q <= issue;
      drop_q     <= redirect_i;
      misalign_q <= misalign_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .entry_i ('{pc: req_pc_q, instr: bus.imem_rdata_i}),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.imem_req_o  = issue;
  assign bus.imem_addr_o = pc_q;
  assign bus.instr_o     = head.instr;
  assign bus.pc_o        = head.pc;
  assign misalign_o      = misalign_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of reset, streaming, backpressure, redirect, misalign, JAL predecode and mid-stream reset.
module tb_fetch_stage;
  localparam logic [31:0] ADDI = 32'h0050_0A13;
  localparam logic [31:0] JAL8 = 32'h0100_00EF;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign;
  logic        jal_en = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  fetch_if bus ();

  fetch_stage dut (
    .clk           (clk),
    .nrst          (nrst),
    .bus           (bus),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .misalign_o    (misalign)
  );

  always #5 clk = ~clk;

  initial bus.imem_rdata_i = '0;
  always @(posedge clk)
    if (bus.imem_req_o) bus.imem_rdata_i <= (jal_en && bus.imem_addr_o == 32'h8) ? JAL8 : ADDI;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_release(input logic rdy);
    nrst = 1'b0;
    tick();
    tick();
    bus.ready_i = rdy;
    nrst = 1'b1;
    #1;
  endtask

  logic [31:0] pcs[$];
  logic [31:0] ins[$];

  initial begin
    bus.ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_req", bus.imem_req_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_instr", bus.instr_o, 0);
    chk("rst_pc", bus.pc_o, 0);
    chk("rst_mis", misalign, 0);
    nrst = 1'b1;
    #1;
    chk("a_req0", bus.imem_req_o, 1);
    chk("a_addr0", bus.imem_addr_o, 32'h0);
    tick();
    chk("a_valid_c1", bus.valid_o, 0);
    chk("a_addr1", bus.imem_addr_o, 32'h4);
    tick();
    chk("a_valid_c2", bus.valid_o, 1);
    chk("a_instr", bus.instr_o, ADDI);
    for (int i = 0; i < 4; i++) begin
      chk("a_pc_seq", bus.pc_o, 32'(i * 4));
      chk("a_valid_seq", bus.valid_o, 1);
      tick();
    end

    rst_release(1'b0);
    chk("b_addr0", bus.imem_addr_o, 32'h0);
    tick();
    chk("b_req1", bus.imem_req_o, 1);
    chk("b_addr1", bus.imem_addr_o, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b_stall_req", bus.imem_req_o, 0);
      chk("b_hold_valid", bus.valid_o, 1);
      chk("b_hold_pc", bus.pc_o, 32'h0);
    end
    bus.ready_i = 1'b1;
    #1;
    chk("b_pop0", bus.pc_o, 32'h0);
    chk("b_resume_req", bus.imem_req_o, 1);
    chk("b_resume_addr", bus.imem_addr_o, 32'h8);
    tick();
    chk("b_pop4", bus.pc_o, 32'h4);
    chk("b_pop4_valid", bus.valid_o, 1);
    tick();
    chk("b_pop8", bus.pc_o, 32'h8);

    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("c_valid_redir", bus.valid_o, 0);
    chk("c_req_redir", bus.imem_req_o, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("c_mis", misalign, 0);
    chk("c_valid_empty", bus.valid_o, 0);
    chk("c_req", bus.imem_req_o, 1);
    chk("c_addr", bus.imem_addr_o, 32'h100);
    tick();
    chk("c_valid_wait", bus.valid_o, 0);
    chk("c_addr2", bus.imem_addr_o, 32'h104);
    tick();
    chk("c_valid_first", bus.valid_o, 1);
    chk("c_pc_first", bus.pc_o, 32'h100);
    tick();
    chk("c_pc_second", bus.pc_o, 32'h104);

    redirect = 1'b1;
    redirect_pc = 32'h102;
    #1;
    chk("d_mis_pre", misalign, 0);
    tick();
    redirect = 1'b0;
    #1;
    chk("d_mis_pulse", misalign, 1);
    chk("d_addr", bus.imem_addr_o, 32'h100);
    chk("d_req", bus.imem_req_o, 1);
    tick();
    chk("d_mis_end", misalign, 0);

    jal_en = 1'b1;
    rst_release(1'b1);
    for (int i = 0; i < 20 && pcs.size() < 4; i++) begin
      if (bus.valid_o && bus.ready_i) begin
        pcs.push_back(bus.pc_o);
        ins.push_back(bus.instr_o);
      end
      tick();
    end
    chk("e_count", 32'(pcs.size()), 4);
    if (pcs.size() == 4) begin
      chk("e_pc0", pcs[0], 32'h0);
      chk("e_pc1", pcs[1], 32'h4);
      chk("e_pc2", pcs[2], 32'h8);
      chk("e_instr_jal", ins[2], JAL8);
`ifdef FETCH_JAL_PREDECODE_EN
      chk("e_pc_target", pcs[3], 32'h18);
`else
      chk("e_pc_seq", pcs[3], 32'hC);
`endif
    end
    jal_en = 1'b0;

    rst_release(1'b1);
    tick();
    tick();
    chk("f_stream_valid", bus.valid_o, 1);
    nrst = 1'b0;
    #1;
    chk("f_req", bus.imem_req_o, 0);
    chk("f_valid", bus.valid_o, 0);
    chk("f_instr", bus.instr_o, 0);
    chk("f_pc", bus.pc_o, 0);
    tick();
    nrst = 1'b1;
    #1;
    chk("f_restart_addr", bus.imem_addr_o, 32'h0);
    chk("f_restart_req", bus.imem_req_o, 1);
    tick();
    chk("f_no_stale", bus.valid_o, 0);
    tick();
    chk("f_first_valid", bus.valid_o, 1);
    chk("f_first_pc", bus.pc_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
